// File: rtl/byte_striping_param.sv
// byte_striping_param: round-robin byte striper for the multi-lane PHY transmit path.
// Collects DATA_W-bit symbols into a lane group of ACT = min(1<<laneWidth, LANES)
// lanes and presents each complete group through a one-entry output register.
// Optional feature macro: STRIPING_PAD_EN enables flushIN, which closes a partial
// group by filling the remaining active lanes with PAD_BYTE.
// laneWidth is sampled into the active lane count whenever the collect buffer is
// (or is about to become) empty, so a new width must be presented one cycle
// before the first byte of the group it should apply to.
module byte_striping_param #(
    parameter int                LANES    = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PAD_BYTE = 8'hF7
) (
    input  logic                     stripingCLK,
    input  logic                     stripingRST,
    input  logic [DATA_W-1:0]        byteStripingIN,
    input  logic                     byteStripingVLD,
    output logic                     byteStripingRDY,
    input  logic [1:0]               laneWidth,
    input  logic                     flushIN,
    output logic [LANES*DATA_W-1:0]  stripedLanes,
    output logic [LANES-1:0]         stripedMask,
    output logic                     stripedVLD,
    input  logic                     stripedRDY
);

    localparam int         PTR_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [3:0] LANES_C = 4'(LANES);

    localparam logic [0:0] COL_EMPTY   = 1'b0;
    localparam logic [0:0] COL_FILLING = 1'b1;
    localparam logic [0:0] OUT_IDLE    = 1'b0;
    localparam logic [0:0] OUT_FULL    = 1'b1;

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [3:0]              act_q, act_d;
    logic [0:0]              out_q, out_d;
    logic [0:0]              col_state;
    logic [DATA_W-1:0]       coll_q [LANES];
    logic [LANES*DATA_W-1:0] lanes_q, lanes_d;
    logic [LANES-1:0]        mask_q, mask_d;

    logic [3:0] ptr_ext;
    logic [3:0] last_ptr;
    logic [3:0] sel_w;
    logic [3:0] act_sel;
    logic       at_last;
    logic       out_free;
    logic       accept;
    logic       complete;
    logic       flush_fire;

    // Handshake, group-completion and width-selection decode
    always_comb begin
        ptr_ext   = 4'(wr_ptr_q);
        last_ptr  = act_q - 4'd1;
        at_last   = (ptr_ext == last_ptr);
        col_state = (wr_ptr_q == '0) ? COL_EMPTY : COL_FILLING;
        out_free  = (out_q == OUT_IDLE) || stripedRDY;

        // Only the byte that would complete a group can stall.
        byteStripingRDY = !stripingRST && (!at_last || out_free);
        accept          = byteStripingVLD && byteStripingRDY;

`ifdef STRIPING_PAD_EN
        // A flush closes whatever is buffered (including a byte accepted now),
        // but only when the output register can take the group.
        flush_fire = flushIN && !stripingRST && out_free &&
                     ((col_state == COL_FILLING) || accept);
`else
        flush_fire = 1'b0;
`endif
        complete = (accept && at_last) || flush_fire;

        sel_w   = 4'd1 << laneWidth;
        act_sel = (sel_w > LANES_C) ? LANES_C : sel_w;

        if (complete) begin
            wr_ptr_d = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // Width only changes at a group boundary: idle-empty or completing.
        if (((col_state == COL_EMPTY) && !accept) || complete) begin
            act_d = act_sel;
        end else begin
            act_d = act_q;
        end

        if (complete) begin
            out_d = OUT_FULL;
        end else if (stripedRDY) begin
            out_d = OUT_IDLE;
        end else begin
            out_d = out_q;
        end
    end

    // Assemble the outgoing group: buffered bytes, the byte accepted now, pad, zero
    always_comb begin
        lanes_d = '0;
        mask_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (4'(i) < act_q) begin
                mask_d[i] = 1'b1;
                if (4'(i) < ptr_ext) begin
                    lanes_d[i*DATA_W +: DATA_W] = coll_q[i];
                end else if ((4'(i) == ptr_ext) && accept) begin
                    lanes_d[i*DATA_W +: DATA_W] = byteStripingIN;
                end else begin
                    lanes_d[i*DATA_W +: DATA_W] = PAD_BYTE;
                end
            end
        end
    end

    // Control state and output register, cleared by reset
    always_ff @(posedge stripingCLK) begin
        if (stripingRST) begin
            wr_ptr_q <= '0;
            act_q    <= LANES_C;
            out_q    <= OUT_IDLE;
            lanes_q  <= '0;
            mask_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            act_q    <= act_d;
            out_q    <= out_d;
            if (complete) begin
                lanes_q <= lanes_d;
                mask_q  <= mask_d;
            end
        end
    end

    // Collect buffer storage; stale contents are never read past wrPtr
    always_ff @(posedge stripingCLK) begin
        if (accept) begin
            coll_q[wr_ptr_q] <= byteStripingIN;
        end
    end

    assign stripedLanes = lanes_q;
    assign stripedMask  = mask_q;
    assign stripedVLD   = (out_q == OUT_FULL);

endmodule

// File: tb/tb_byte_striping_param.sv
// Testbench for byte_striping_param (LANES=4, DATA_W=8): directed vectors with a
// queue-based scoreboard checked by an independent output monitor.
module tb_byte_striping_param;

    typedef struct packed {
        logic [31:0] lanes;
        logic [3:0]  mask;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        vld;
    logic        rdy;
    logic [1:0]  lw;
    logic        flush;
    logic [31:0] lanes;
    logic [3:0]  mask;
    logic        ovld;
    logic        ordy;

    int   tests = 0;
    int   fails = 0;
    grp_t exp_q[$];

    byte_striping_param #(.LANES(4), .DATA_W(8), .PAD_BYTE(8'hF7)) dut (
        .stripingCLK    (clk),
        .stripingRST    (rst),
        .byteStripingIN (din),
        .byteStripingVLD(vld),
        .byteStripingRDY(rdy),
        .laneWidth      (lw),
        .flushIN        (flush),
        .stripedLanes   (lanes),
        .stripedMask    (mask),
        .stripedVLD     (ovld),
        .stripedRDY     (ordy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic expect_grp(input logic [31:0] l, input logic [3:0] m);
        grp_t g;
        g.lanes = l;
        g.mask  = m;
        exp_q.push_back(g);
    endtask

    // Present one byte and hold it until accepted (bounded wait)
    task automatic send(input logic [7:0] b);
        int n;
        n   = 0;
        din = b;
        vld = 1'b1;
        @(negedge clk);
        while (!rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %02h not accepted, rdy %0b expected 1", b, rdy);
        end
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every transferred group is checked against the scoreboard
    always @(negedge clk) begin
        if (!rst && ovld && ordy) begin
            grp_t g;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_group: got %08h/%h expected none", lanes, mask);
            end else begin
                g = exp_q.pop_front();
                if (lanes !== g.lanes || mask !== g.mask) begin
                    fails++;
                    $display("FAIL group: got %08h/%h expected %08h/%h", lanes, mask, g.lanes, g.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; din = 8'h00; vld = 1'b0; lw = 2'd2; flush = 1'b0; ordy = 1'b1;
        idle(3);
        @(negedge clk);
        check("reset_vld",   {31'd0, ovld}, 32'd0);
        check("reset_lanes", lanes, 32'd0);
        check("reset_mask",  {28'd0, mask}, 32'd0);
        check("reset_rdy",   {31'd0, rdy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // x4 basic group and one-cycle latency
        expect_grp(32'h44332211, 4'hF);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("x4_latency_vld",   {31'd0, ovld}, 32'd1);
        check("x4_latency_lanes", lanes, 32'h44332211);
        idle(2);

        // x2, then a mid-group width change that only affects the next group
        lw = 2'd1;
        idle(2);
        expect_grp(32'h0000B2A1, 4'h3);
        send(8'hA1); send(8'hB2);
        expect_grp(32'h0000B2A1, 4'h3);
        send(8'hA1);
        lw = 2'd2;
        send(8'hB2);
        expect_grp(32'h04030201, 4'hF);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);

        // Output backpressure: first group held, completing byte stalls
        ordy = 1'b0;
        expect_grp(32'h44332211, 4'hF);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77);
        expect_grp(32'h88776655, 4'hF);
        din = 8'h88;
        vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rdy",   {31'd0, rdy}, 32'd0);
            check("stall_hold",  lanes, 32'h44332211);
        end
        @(posedge clk); #1;
        ordy = 1'b1;
        @(negedge clk);
        check("stall_release_rdy", {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
        vld = 1'b0;
        @(negedge clk);
        check("stall_second_vld", {31'd0, ovld}, 32'd1);
        idle(2);

        // Partial group with flush
        send(8'h55); send(8'h66);
`ifdef STRIPING_PAD_EN
        expect_grp(32'hF7F76655, 4'hF);
`endif
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
`ifdef STRIPING_PAD_EN
        @(negedge clk);
        check("pad_vld", {31'd0, ovld}, 32'd1);
        idle(2);
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nopad_no_output", {31'd0, ovld}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
`endif

        // Reset mid-group discards the partial group
        send(8'h01); send(8'h02);
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        check("midrst_vld",   {31'd0, ovld}, 32'd0);
        check("midrst_lanes", lanes, 32'd0);
        check("midrst_mask",  {28'd0, mask}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        expect_grp(32'h04030201, 4'hF);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);

        // x1 back-to-back, one group per cycle
        lw = 2'd0;
        idle(2);
        expect_grp(32'h00000010, 4'h1);
        expect_grp(32'h00000020, 4'h1);
        expect_grp(32'h00000030, 4'h1);
        send(8'h10);
        check("x1_first_lanes", lanes, 32'h00000010);
        send(8'h20);
        check("x1_second_lanes", lanes, 32'h00000020);
        send(8'h30);
        check("x1_third_lanes", lanes, 32'h00000030);
        idle(4);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
